riscv_mem_arbiter: RTL and testbench

- Shares one synchronous-read, single-port unified memory between two requesters: the CPU instruction-fetch port (IF) and the load/store port (LS).
- Sits between riscv_cpu and the unified memory, replacing the separate imem/dmem arrangement.
- Makes a per-cycle grant decision and returns read data one cycle after the grant.
- Has a fixed-priority mode (LS first) with an IF starvation guard, and a round-robin mode.

---
 rtl/riscv_mem_arbiter.sv | 70 +++++++
 tb/tb_riscv_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one synchronous-read memory between instruction-fetch and load/store ports
module riscv_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_BIT = 12,
  parameter bit RR_MODE  = 1'b0,
  parameter int MAX_WAIT = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_arb_if_req,
  input  logic [XLEN-1:0]     i_arb_if_addr,
  output logic                o_arb_if_gnt,
  output logic                o_arb_if_rvalid,
  output logic [XLEN-1:0]     o_arb_if_rdata,
  input  logic                i_arb_ls_req,
  input  logic [XLEN-1:0]     i_arb_ls_addr,
  input  logic                i_arb_ls_wr_en,
  input  logic [3:0]          i_arb_ls_byte_sel,
  input  logic [XLEN-1:0]     i_arb_ls_wr_data,
  output logic                o_arb_ls_gnt,
  output logic                o_arb_ls_rvalid,
  output logic [XLEN-1:0]     o_arb_ls_rdata,
  output logic [ADDR_BIT-3:0] o_arb_mem_addr,
  output logic                o_arb_mem_wr_en,
  output logic [3:0]          o_arb_mem_byte_sel,
  output logic [XLEN-1:0]     o_arb_mem_wr_data,
  input  logic [XLEN-1:0]     i_arb_mem_rd_data
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;
  logic last_ls, if_win, if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic [ADDR_BIT-3:0] gnt_addr;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_arb_if_addr[XLEN-1:ADDR_BIT], i_arb_if_addr[1:0],
                              i_arb_ls_addr[XLEN-1:ADDR_BIT], i_arb_ls_addr[1:0]};
  // grant decision: IF wins a contested cycle on starvation (fixed mode) or when LS won last (round-robin)
  always_comb begin
    if_win   = RR_MODE ? last_ls : (wait_cnt == MW);
    if_gnt   = !i_rst && i_arb_if_req && (!i_arb_ls_req || if_win);
    ls_gnt   = !i_rst && i_arb_ls_req && !if_gnt;
    gnt_addr = if_gnt ? i_arb_if_addr[ADDR_BIT-1:2] : i_arb_ls_addr[ADDR_BIT-1:2];
  end
  // drive the memory from the granted requester, all zero when idle
  always_comb begin
    o_arb_mem_addr     = (if_gnt || ls_gnt) ? gnt_addr : '0;
    o_arb_mem_wr_en    = ls_gnt && i_arb_ls_wr_en;
    o_arb_mem_byte_sel = if_gnt ? 4'hF : ls_gnt ? i_arb_ls_byte_sel : 4'h0;
    o_arb_mem_wr_data  = ls_gnt ? i_arb_ls_wr_data : '0;
  end
  assign o_arb_if_gnt    = if_gnt;
  assign o_arb_ls_gnt    = ls_gnt;
  assign o_arb_if_rvalid = if_rvalid;
  assign o_arb_ls_rvalid = ls_rvalid;
  assign o_arb_if_rdata  = if_rvalid ? i_arb_mem_rd_data : '0;
  assign o_arb_ls_rdata  = ls_rvalid ? i_arb_mem_rd_data : '0;
  // starvation counter, round-robin pointer and one-cycle read-return tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt  <= '0;
      last_ls   <= 1'b1;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      wait_cnt  <= (i_arb_if_req && !if_gnt) ? ((wait_cnt == MW) ? MW : wait_cnt + 4'd1) : '0;
      last_ls   <= if_gnt ? 1'b0 : ls_gnt ? 1'b1 : last_ls;
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt && !i_arb_ls_wr_en;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: checks fixed-priority and round-robin arbiter instances against a behavioural model
module tb_riscv_mem_arbiter;
  localparam int MAXW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
  logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wd = 32'h0;
  logic [3:0] ls_bs = 4'h0;
  logic if_gnt [2], if_rv [2], ls_gnt [2], ls_rv [2], m_we [2];
  logic [31:0] if_rd [2], ls_rd [2], m_wd [2], m_rd [2];
  logic [9:0] m_addr [2];
  logic [3:0] m_bs [2];
  logic [31:0] mem [2][1024];
  logic [31:0] rmem [2][1024];
  bit loaded = 1'b0;
  int wc = 0;
  bit last_ls = 1'b1;
  bit e_rvif [2], e_rvls [2];
  logic [31:0] e_rdq [2];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.RR_MODE(1'b0), .MAX_WAIT(MAXW)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_arb_if_req(if_req), .i_arb_if_addr(if_addr),
    .o_arb_if_gnt(if_gnt[0]), .o_arb_if_rvalid(if_rv[0]), .o_arb_if_rdata(if_rd[0]),
    .i_arb_ls_req(ls_req), .i_arb_ls_addr(ls_addr), .i_arb_ls_wr_en(ls_wr),
    .i_arb_ls_byte_sel(ls_bs), .i_arb_ls_wr_data(ls_wd),
    .o_arb_ls_gnt(ls_gnt[0]), .o_arb_ls_rvalid(ls_rv[0]), .o_arb_ls_rdata(ls_rd[0]),
    .o_arb_mem_addr(m_addr[0]), .o_arb_mem_wr_en(m_we[0]), .o_arb_mem_byte_sel(m_bs[0]),
    .o_arb_mem_wr_data(m_wd[0]), .i_arb_mem_rd_data(m_rd[0])
  );

  riscv_mem_arbiter #(.RR_MODE(1'b1), .MAX_WAIT(MAXW)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_arb_if_req(if_req), .i_arb_if_addr(if_addr),
    .o_arb_if_gnt(if_gnt[1]), .o_arb_if_rvalid(if_rv[1]), .o_arb_if_rdata(if_rd[1]),
    .i_arb_ls_req(ls_req), .i_arb_ls_addr(ls_addr), .i_arb_ls_wr_en(ls_wr),
    .i_arb_ls_byte_sel(ls_bs), .i_arb_ls_wr_data(ls_wd),
    .o_arb_ls_gnt(ls_gnt[1]), .o_arb_ls_rvalid(ls_rv[1]), .o_arb_ls_rdata(ls_rd[1]),
    .o_arb_mem_addr(m_addr[1]), .o_arb_mem_wr_en(m_we[1]), .o_arb_mem_byte_sel(m_bs[1]),
    .o_arb_mem_wr_data(m_wd[1]), .i_arb_mem_rd_data(m_rd[1])
  );

  // expected winner {if, ls} for instance k (0 = fixed priority, 1 = round-robin)
  function automatic logic [1:0] pick(int k);
    if (rst || !(if_req || ls_req)) return 2'b00;
    if (!ls_req) return 2'b10;
    if (!if_req) return 2'b01;
    if (k == 0) return (wc == MAXW) ? 2'b10 : 2'b01;
    return last_ls ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [114:0] expect_out(int k);
    logic [1:0] g;
    logic [31:0] a;
    logic ri, rl;
    g  = pick(k);
    a  = (g == 2'b10) ? if_addr : ls_addr;
    ri = e_rvif[k] && !rst;
    rl = e_rvls[k] && !rst;
    return {g[1], ri, ri ? e_rdq[k] : 32'h0, g[0], rl, rl ? e_rdq[k] : 32'h0,
            (g != 2'b00) ? a[11:2] : 10'h0, g[0] && ls_wr,
            g[1] ? 4'hF : (g[0] ? ls_bs : 4'h0), g[0] ? ls_wd : 32'h0};
  endfunction

  function automatic logic [114:0] got(int k);
    return {if_gnt[k], if_rv[k], if_rd[k], ls_gnt[k], ls_rv[k], ls_rd[k],
            m_addr[k], m_we[k], m_bs[k], m_wd[k]};
  endfunction

  // memories seen by each DUT plus the model's own shadow copies
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 1024; i++) begin
          mem[k][i]  <= {16'hC0DE, 16'(i)};
          rmem[k][i] <= {16'hC0DE, 16'(i)};
        end
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (m_we[k] && m_bs[k][b]) mem[k][m_addr[k]][8*b+:8] <= m_wd[k][8*b+:8];
          if (pick(k) == 2'b01 && ls_wr && ls_bs[b]) rmem[k][ls_addr[11:2]][8*b+:8] <= ls_wd[8*b+:8];
        end
        m_rd[k] <= mem[k][m_addr[k]];
      end
    end
  end

  // model state: IF denial streak, last winner, pending read returns
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_rvif[k] <= (pick(k) == 2'b10);
      e_rvls[k] <= (pick(k) == 2'b01) && !ls_wr;
      e_rdq[k]  <= (pick(k) == 2'b10) ? rmem[k][if_addr[11:2]] : rmem[k][ls_addr[11:2]];
    end
    wc      <= rst ? 0 : (if_req && pick(0) != 2'b10) ? ((wc < MAXW) ? wc + 1 : MAXW) : 0;
    last_ls <= rst ? 1'b1 : (pick(1) == 2'b10) ? 1'b0 : (pick(1) == 2'b01) ? 1'b1 : last_ls;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h10; ls_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({if_gnt[k], ls_gnt[k], m_we[k], if_rv[k], ls_rv[k]} !== 5'b0) begin
          errors++;
          $display("FAIL reset_hold inst%0d got=%b want=00000", k, {if_gnt[k], ls_gnt[k], m_we[k], if_rv[k], ls_rv[k]});
        end
      end
      next_cycle();
    end
    rst = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({if_gnt[k], m_addr[k]} !== {1'b1, 10'd4}) begin
        errors++;
        $display("FAIL reset_release_gnt inst%0d got gnt=%b addr=%0d want gnt=1 addr=4", k, if_gnt[k], m_addr[k]);
      end
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({if_rv[k], if_rd[k]} !== {1'b1, 32'hC0DE0004}) begin
        errors++;
        $display("FAIL reset_release_rdata inst%0d got rv=%b rd=%h want rv=1 rd=c0de0004", k, if_rv[k], if_rd[k]);
      end
    end
    next_cycle();
  endtask

  task automatic test_ls_write;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h24; ls_bs = 4'b0011; ls_wd = 32'hA5A51234;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ls_gnt[k], m_addr[k], m_we[k], m_bs[k], m_wd[k]} !== {1'b1, 10'd9, 1'b1, 4'h3, 32'hA5A51234}) begin
        errors++;
        $display("FAIL ls_write_drive inst%0d got gnt=%b addr=%0d we=%b bs=%h wd=%h want 1/9/1/3/a5a51234",
                 k, ls_gnt[k], m_addr[k], m_we[k], m_bs[k], m_wd[k]);
      end
    end
    next_cycle();
    ls_wr = 1'b0; ls_bs = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ls_gnt[k], ls_rv[k], m_we[k]} !== 3'b100) begin
        errors++;
        $display("FAIL ls_write_no_rvalid inst%0d got gnt/rv/we=%b want 100", k, {ls_gnt[k], ls_rv[k], m_we[k]});
      end
    end
    next_cycle();
    ls_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ls_rv[k], ls_rd[k]} !== {1'b1, 32'hC0DE1234}) begin
        errors++;
        $display("FAIL ls_readback inst%0d got rv=%b rd=%h want rv=1 rd=c0de1234", k, ls_rv[k], ls_rd[k]);
      end
    end
    next_cycle();
  endtask

  task automatic test_fixed_priority;
    logic [2:0] e;
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    next_cycle();
    if_req = 1'b1; ls_req = 1'b1; if_addr = $urandom; ls_addr = $urandom;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = {(i % 4 == 3), (i % 4 != 3), (i > 0 && i % 4 == 0)};
      checks++;
      if ({if_gnt[0], ls_gnt[0], if_rv[0]} !== e) begin
        errors++;
        $display("FAIL fixed_pattern cycle%0d got if/ls/ifrv=%b want %b", i, {if_gnt[0], ls_gnt[0], if_rv[0]}, e);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got(k) !== expect_out(k)) begin
          errors++;
          $display("FAIL fixed_model inst%0d cycle%0d got=%h want=%h", k, i, got(k), expect_out(k));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] e;
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
    rst = 1'b0; ls_req = 1'b1; if_addr = $urandom; ls_addr = $urandom;
    for (int i = 0; i < 10; i++) begin
      if_req = !(i == 6 || i == 7);
      @(negedge clk);
      e = (i < 6) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : (i < 8) ? 2'b01 : (i == 8) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt[1], ls_gnt[1]} !== e) begin
        errors++;
        $display("FAIL rr_pattern cycle%0d got if/ls=%b want %b", i, {if_gnt[1], ls_gnt[1]}, e);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got(k) !== expect_out(k)) begin
          errors++;
          $display("FAIL rr_model inst%0d cycle%0d got=%h want=%h", k, i, got(k), expect_out(k));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (if_gnt[k] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_gnt inst%0d got=%b want=1", k, if_gnt[k]);
      end
    end
    next_cycle();
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (if_rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_rvalid inst%0d got=%b want=0", k, if_rv[k]);
      end
    end
    next_cycle();
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt[0], ls_gnt[0], if_gnt[1], ls_gnt[1]} !== 4'b0110) begin
      errors++;
      $display("FAIL mid_reset_after got=%b want=0110", {if_gnt[0], ls_gnt[0], if_gnt[1], ls_gnt[1]});
    end
    next_cycle();
  endtask

  task automatic test_random;
    for (int i = 0; i < 500; i++) begin
      rst     = ($urandom_range(0, 39) == 0);
      if_req  = 1'($urandom_range(0, 1));
      ls_req  = 1'($urandom_range(0, 1));
      ls_wr   = 1'($urandom_range(0, 1));
      if_addr = $urandom;
      ls_addr = $urandom;
      ls_bs   = 4'($urandom);
      ls_wd   = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got(k) !== expect_out(k)) begin
          errors++;
          $display("FAIL random_model inst%0d cycle%0d got=%h want=%h", k, i, got(k), expect_out(k));
        end
      end
      next_cycle();
    end
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ls_write();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
